// File: rtl/block_write_mem.sv
// Block FIFO: QUEUE_SIZE entries of DATA_SIZE bits with registered pop data and
// sticky overflow/underflow flags. A write while full succeeds only alongside a pop.
module block_write_mem #(
    parameter int INDEX_PTR  = 2,
    parameter int QUEUE_SIZE = 2**INDEX_PTR,
    parameter int DATA_SIZE  = 128
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 wr_en,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 rd_en,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic [INDEX_PTR:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [INDEX_PTR-1:0] LAST_IDX = INDEX_PTR'(QUEUE_SIZE - 1);
    localparam logic [INDEX_PTR:0]   FULL_CNT = (INDEX_PTR+1)'(QUEUE_SIZE);

    logic [DATA_SIZE-1:0] mem [QUEUE_SIZE];

    logic [INDEX_PTR-1:0] wr_ptr_q, wr_ptr_d;
    logic [INDEX_PTR-1:0] rd_ptr_q, rd_ptr_d;
    logic [INDEX_PTR:0]   count_q, count_d;
    logic [DATA_SIZE-1:0] data_out_q, data_out_d;
    logic                 valid_q, valid_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 wr_accept, rd_accept;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // A pop frees a slot in the same edge, so a full FIFO still takes the write.
    assign rd_accept = rd_en && !empty;
    assign wr_accept = wr_en && (!full || rd_en);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        valid_d     = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_accept) begin
            wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d   = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
            data_out_d = mem[rd_ptr_q];
            valid_d    = 1'b1;
        end
        if (wr_accept && !rd_accept) begin
            count_d = count_q + 1'b1;
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - 1'b1;
        end
        if (wr_en && full && !rd_en) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never reset; reset_L gates the write so a mid-cycle reset discards it.
    always_ff @(posedge clk) begin
        if (reset_L && wr_accept) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_block_write_mem.sv
// Directed bench for block_write_mem: ordering, full/empty corner cases,
// sticky flags, pointer wrap and asynchronous reset.
module tb_block_write_mem;

    logic         clk = 1'b0;
    logic         reset_L;
    logic         wr_en;
    logic [127:0] data_in;
    logic         rd_en;
    logic [127:0] data_out;
    logic         valid_out;
    logic [2:0]   count;
    logic         full;
    logic         empty;
    logic         overflow;
    logic         underflow;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] VA = 128'h397d9f2f40ca9e6c6b1f3324fded873c;
    localparam logic [127:0] VB = 128'hba23491e0f98ed0e2e3128e184aefe0f;
    localparam logic [127:0] VX = 128'h8855c7ac8b73f8f29701eff1ba0f98b3;
    localparam logic [127:0] VN = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] VC = 128'hcafef00d_deadbeef_12345678_9abcdef0;
    localparam logic [127:0] VF = 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;

    logic [127:0] fill_vec [4];
    logic [127:0] pair_vec [10];

    always #5 clk = ~clk;

    block_write_mem dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .wr_en     (wr_en),
        .data_in   (data_in),
        .rd_en     (rd_en),
        .data_out  (data_out),
        .valid_out (valid_out),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic w, input logic r, input logic [127:0] d);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        step();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        $display("op wr=%0b rd=%0b din=%h -> dout=%h valid=%0b count=%0d full=%0b empty=%0b ovf=%0b unf=%0b",
                 w, r, d, data_out, valid_out, count, full, empty, overflow, underflow);
    endtask

    initial begin
        fill_vec[0] = 128'h11111111_22222222_33333333_44444444;
        fill_vec[1] = 128'h55555555_66666666_77777777_88888888;
        fill_vec[2] = 128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc;
        fill_vec[3] = 128'hdddddddd_eeeeeeee_ffffffff_00000001;
        for (int i = 0; i < 10; i++) begin
            pair_vec[i] = {4{32'h1000_0000 + 32'(i) * 32'h0101_0101}};
        end

        reset_L = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        step();
        step();
        check("rst_count", 128'(count), 128'd0);
        check("rst_empty", 128'(empty), 128'd1);
        check("rst_full", 128'(full), 128'd0);
        check("rst_valid", 128'(valid_out), 128'd0);
        check("rst_dout", data_out, 128'd0);
        check("rst_flags", 128'({overflow, underflow}), 128'd0);
        reset_L = 1'b1;

        // Two writes then two pops in order
        op(1'b1, 1'b0, VA);
        op(1'b1, 1'b0, VB);
        check("two_count", 128'(count), 128'd2);
        op(1'b0, 1'b1, '0);
        check("pop1_data", data_out, VA);
        check("pop1_valid", 128'(valid_out), 128'd1);
        check("pop1_count", 128'(count), 128'd1);
        op(1'b0, 1'b1, '0);
        check("pop2_data", data_out, VB);
        check("pop2_valid", 128'(valid_out), 128'd1);
        check("pop2_count", 128'(count), 128'd0);
        check("pop2_empty", 128'(empty), 128'd1);
        op(1'b0, 1'b0, '0);
        check("idle_valid", 128'(valid_out), 128'd0);
        check("idle_dout", data_out, VB);

        // Fill, then simultaneous write+read while full
        for (int i = 0; i < 4; i++) op(1'b1, 1'b0, fill_vec[i]);
        check("fill_full", 128'(full), 128'd1);
        check("fill_count", 128'(count), 128'd4);
        op(1'b1, 1'b1, VN);
        check("wr_rd_full_data", data_out, fill_vec[0]);
        check("wr_rd_full_valid", 128'(valid_out), 128'd1);
        check("wr_rd_full_count", 128'(count), 128'd4);
        check("wr_rd_full_ovf", 128'(overflow), 128'd0);

        // Dropped write while full
        op(1'b1, 1'b0, VX);
        check("drop_full", 128'(full), 128'd1);
        check("drop_count", 128'(count), 128'd4);
        check("drop_ovf", 128'(overflow), 128'd1);
        check("drop_valid", 128'(valid_out), 128'd0);
        for (int i = 1; i < 4; i++) begin
            op(1'b0, 1'b1, '0);
            check($sformatf("drain%0d_data", i), data_out, fill_vec[i]);
        end
        op(1'b0, 1'b1, '0);
        check("drain_last_data", data_out, VN);
        check("drain_empty", 128'(empty), 128'd1);
        op(1'b0, 1'b1, '0);
        check("x_never_popped_valid", 128'(valid_out), 128'd0);
        check("x_never_popped_dout", data_out, VN);
        check("ovf_sticky", 128'(overflow), 128'd1);

        // Read while empty plus simultaneous write; underflow already set above, so check it from a fresh reset
        reset_L = 1'b0;
        #1;
        reset_L = 1'b1;
        check("unf_pre", 128'(underflow), 128'd0);
        op(1'b1, 1'b0, VA);
        op(1'b0, 1'b1, '0);
        check("pre_empty_dout", data_out, VA);
        op(1'b1, 1'b1, VC);
        check("empty_rd_valid", 128'(valid_out), 128'd0);
        check("empty_rd_dout", data_out, VA);
        check("empty_rd_unf", 128'(underflow), 128'd1);
        check("empty_rd_count", 128'(count), 128'd1);
        op(1'b0, 1'b1, '0);
        check("empty_rd_wr_data", data_out, VC);
        check("unf_sticky", 128'(underflow), 128'd1);

        // Ten write/read pairs wrap the pointers
        for (int i = 0; i < 10; i++) begin
            op(1'b1, 1'b0, pair_vec[i]);
            op(1'b0, 1'b1, '0);
            check($sformatf("pair%0d_data", i), data_out, pair_vec[i]);
            check($sformatf("pair%0d_valid", i), 128'(valid_out), 128'd1);
        end
        check("pairs_count", 128'(count), 128'd0);

        // Asynchronous reset with count=3 and overflow set
        for (int i = 0; i < 4; i++) op(1'b1, 1'b0, fill_vec[i]);
        op(1'b1, 1'b0, VX);
        op(1'b0, 1'b1, '0);
        check("pre_arst_count", 128'(count), 128'd3);
        check("pre_arst_ovf", 128'(overflow), 128'd1);
        wr_en   = 1'b1;
        data_in = VX;
        #2;
        reset_L = 1'b0;
        #1;
        check("arst_count", 128'(count), 128'd0);
        check("arst_empty", 128'(empty), 128'd1);
        check("arst_ovf", 128'(overflow), 128'd0);
        check("arst_unf", 128'(underflow), 128'd0);
        check("arst_dout", data_out, 128'd0);
        check("arst_valid", 128'(valid_out), 128'd0);
        step();
        wr_en   = 1'b0;
        reset_L = 1'b1;
        step();
        check("post_arst_count", 128'(count), 128'd0);
        op(1'b1, 1'b0, VF);
        op(1'b0, 1'b1, '0);
        check("post_arst_data", data_out, VF);
        check("post_arst_empty", 128'(empty), 128'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/block_write_mem.md
BLOCK_WRITE_MEM -- requirements
Module: block_write_mem

Interface
REQ-001 SHALL have parameter INDEX_PTR, default 2, pointer width in bits.
REQ-002 SHALL have parameter QUEUE_SIZE, default 2**INDEX_PTR (4), number of 128-bit entries.
REQ-003 SHALL have parameter DATA_SIZE, default 128, entry width in bits.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_L, input, 1, reset; asynchronous and active-low.
REQ-006 SHALL have port wr_en, input, 1, write request for data_in this cycle.
REQ-007 SHALL have port data_in, input, DATA_SIZE, block to store.
REQ-008 SHALL have port rd_en, input, 1, read request; pops oldest stored block.
REQ-009 SHALL have port data_out, output reg, DATA_SIZE, popped block, registered.
REQ-010 SHALL have port valid_out, output reg, 1, data_out carries a freshly popped block this cycle.
REQ-011 SHALL have port count, output reg, INDEX_PTR+1, number of stored entries (0..QUEUE_SIZE).
REQ-012 SHALL have port full, output, 1, count == QUEUE_SIZE, decoded from registered count only.
REQ-013 SHALL have port empty, output, 1, count == 0, decoded from registered count only.
REQ-014 SHALL have port overflow, output reg, 1, sticky: write was dropped.
REQ-015 SHALL have port underflow, output reg, 1, sticky: read was refused.

Function
REQ-016 SHALL hold QUEUE_SIZE x DATA_SIZE storage addressed by wr_ptr and rd_ptr, each INDEX_PTR bits wide, wrapping modulo QUEUE_SIZE (3 -> 0 at default).
REQ-017 SHALL accept a write when wr_en=1 and (full=0, or full=1 with rd_en=1): mem[wr_ptr] <= data_in, wr_ptr += 1.
REQ-018 SHALL accept a read when rd_en=1 and empty=0: data_out <= mem[rd_ptr], valid_out <= 1, rd_ptr += 1; data becomes visible one cycle after the rd_en edge.
REQ-019 SHALL drive valid_out 0 in any cycle following an edge without an accepted read, with data_out holding its previous value.
REQ-020 SHALL update count: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-021 SHALL, when full with wr_en=1 and rd_en=1, perform both: oldest entry popped, new entry stored in the freed slot, count stays QUEUE_SIZE, overflow unchanged.
REQ-022 SHALL, when full with wr_en=1 and rd_en=0, drop the write (memory, wr_ptr, count unchanged) and set overflow to 1.
REQ-023 SHALL, when empty with rd_en=1, refuse the read (rd_ptr, data_out unchanged, valid_out 0) and set underflow to 1; a simultaneous wr_en=1 is still accepted (count 0 -> 1), with no same-cycle bypass to data_out.
REQ-024 SHALL keep overflow and underflow at 1 once set until reset_L is asserted.
REQ-025 SHALL return entries in write order (FIFO) across any number of pointer wrap-arounds.

Reset
REQ-026 SHALL, while reset_L=0, asynchronously force wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, overflow=0, underflow=0; hence empty=1, full=0.
REQ-027 SHALL not clear storage contents on reset; stale entries are unreachable because count=0.
REQ-028 SHALL discard any in-progress write or read when reset_L falls mid-cycle; first accepted operation is on the first rising edge with reset_L=1.

Verification
REQ-029 SHALL be verified by: reset, write 128'h397d9f2f40ca9e6c6b1f3324fded873c then 128'hba23491e0f98ed0e2e3128e184aefe0f, pop twice -> data_out returns them in order, valid_out=1 on each cycle after rd_en, count 2->1->0, empty=1.
REQ-030 SHALL be verified by: fill 4 entries, then wr_en=1 rd_en=0 with 128'h8855c7ac8b73f8f29701eff1ba0f98b3 -> full=1, count=4, overflow=1, that value never popped.
REQ-031 SHALL be verified by: with full=1, wr_en=1 and rd_en=1 for one cycle -> oldest entry on data_out, count stays 4, overflow stays 0, new entry popped last.
REQ-032 SHALL be verified by: rd_en=1 with empty=1 -> valid_out=0, data_out unchanged, underflow=1; same cycle wr_en=1 -> count=1.
REQ-033 SHALL be verified by: 10 write/read pairs (pointer wrap twice) -> output sequence equals input sequence, count returns to 0.
REQ-034 SHALL be verified by: assert reset_L=0 between clock edges with count=3 and overflow=1 -> outputs cleared immediately without a clock edge, empty=1, overflow=0.
